// File: rtl/rgb2hsv_pkg.sv
// Shared types and constants for the streaming RGB to HSV converter.
package rgb2hsv_pkg;

  typedef enum logic [1:0] {
    SEC_GRAY = 2'd0,
    SEC_R    = 2'd1,
    SEC_G    = 2'd2,
    SEC_B    = 2'd3
  } sector_e;

  localparam int unsigned HUE_W    = 9;
  localparam int unsigned HUE_FULL = 360;

  // Quotient width: wide enough for hue up to 360 and saturation up to 2^SF.
  function automatic int unsigned qw(input int unsigned sf);
    return (sf + 1 > HUE_W) ? sf + 1 : HUE_W;
  endfunction

endpackage

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first, with a
// tag and valid bit travelling alongside each operand pair.
module hsv_div_pipe #(
  parameter int unsigned NW   = 18,
  parameter int unsigned DENW = 9,
  parameter int unsigned QW   = 9,
  parameter int unsigned TW   = 1
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            en,
  input  logic            in_vld,
  input  logic [NW-1:0]   in_num,
  input  logic [DENW-1:0] in_den,
  input  logic [TW-1:0]   in_tag,
  output logic            out_vld,
  output logic [QW-1:0]   out_quo,
  output logic [TW-1:0]   out_tag
);

  localparam int unsigned CW = (NW > DENW + QW) ? NW : DENW + QW;

  logic [QW-1:0]            vld_q;
  logic [QW-1:0][QW-1:0]    quo_q;
  logic [QW-1:0][TW-1:0]    tag_q;
  logic [QW-2:0][NW-1:0]    rem_q;
  logic [QW-2:0][DENW-1:0]  den_q;

  logic [QW-1:0]            vld_c;
  logic [QW-1:0][NW-1:0]    rem_c;
  logic [QW-1:0][DENW-1:0]  den_c;
  logic [QW-1:0][QW-1:0]    quo_c;
  logic [QW-1:0][TW-1:0]    tag_c;
  logic [QW-1:0][CW-1:0]    den_sh;
  logic [QW-1:0]            fits;
  logic [QW-1:0][QW-1:0]    quo_n;
  logic [QW-2:0][NW-1:0]    rem_n;

  // Stage j decides quotient bit QW-1-j against the divisor shifted to that weight.
  always_comb begin
    vld_c  = {vld_q[QW-2:0], in_vld};
    rem_c  = '0;
    den_c  = '0;
    quo_c  = '0;
    tag_c  = '0;
    den_sh = '0;
    fits   = '0;
    quo_n  = '0;
    rem_n  = '0;
    rem_c[0] = in_num;
    den_c[0] = in_den;
    tag_c[0] = in_tag;
    for (int unsigned j = 1; j < QW; j++) begin
      rem_c[j] = rem_q[j-1];
      den_c[j] = den_q[j-1];
      quo_c[j] = quo_q[j-1];
      tag_c[j] = tag_q[j-1];
    end
    for (int unsigned j = 0; j < QW; j++) begin
      den_sh[j] = CW'(den_c[j]) << (QW - 1 - j);
      fits[j]   = CW'(rem_c[j]) >= den_sh[j];
      quo_n[j]  = quo_c[j] | (fits[j] ? (QW'(1) << (QW - 1 - j)) : '0);
    end
    for (int unsigned j = 0; j < QW - 1; j++) begin
      rem_n[j] = fits[j] ? NW'(CW'(rem_c[j]) - den_sh[j]) : rem_c[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_c;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      quo_q <= quo_n;
      tag_q <= tag_c;
      rem_q <= rem_n;
      den_q <= den_c[QW-2:0];
    end
  end

  assign out_vld = vld_q[QW-1];
  assign out_quo = quo_q[QW-1];
  assign out_tag = tag_q[QW-1];

endmodule

// File: rtl/rgb2hsv_stream.sv
// Fully pipelined RGB to HSV converter with valid/ready backpressure and a
// sideband field that travels with each pixel.
module rgb2hsv_stream
  import rgb2hsv_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned SF = 11,
  parameter int unsigned UW = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_g,
  input  logic [DW-1:0]    in_b,
  input  logic [UW-1:0]    in_user,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HUE_W-1:0] out_h,
  output logic [SF-1:0]    out_s,
  output logic [DW-1:0]    out_v,
  output logic [UW-1:0]    out_user
);

  localparam int unsigned QW   = qw(SF);
  localparam int unsigned NUMW = DW + 3;
  localparam int unsigned HNW  = DW + 10;
  localparam int unsigned HDW  = DW + 1;
  localparam int unsigned SNW  = DW + SF;
  localparam int unsigned TW   = 2 + DW + UW + 1;
  localparam logic [QW-1:0] S_ONE = QW'(1) << SF;

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv && reset_b;

  // Stage 0: capture pixel, classify sector
  logic [DW-1:0] c_max, c_min;
  sector_e       c_sec;

  always_comb begin
    c_max = in_r;
    if (in_g > c_max) c_max = in_g;
    if (in_b > c_max) c_max = in_b;
    c_min = in_r;
    if (in_g < c_min) c_min = in_g;
    if (in_b < c_min) c_min = in_b;
    c_sec = SEC_B;
    if (c_max == c_min)    c_sec = SEC_GRAY;
    else if (in_r == c_max) c_sec = SEC_R;
    else if (in_g == c_max) c_sec = SEC_G;
  end

  logic          s0_vld;
  logic [DW-1:0] s0_r, s0_g, s0_b, s0_max, s0_min;
  sector_e       s0_sec;
  logic [UW-1:0] s0_user;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      s0_vld <= 1'b0;
    end else if (adv) begin
      s0_vld <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s0_r    <= in_r;
      s0_g    <= in_g;
      s0_b    <= in_b;
      s0_max  <= c_max;
      s0_min  <= c_min;
      s0_sec  <= c_sec;
      s0_user <= in_user;
    end
  end

  // Stage 1: hue numerator lands in [0, 6*delta); the +delta term makes the
  // later floor division round half-up.
  logic [DW-1:0]   c_delta;
  logic [NUMW-1:0] c_num;
  logic [HNW-1:0]  c_hnum;
  logic [HDW-1:0]  c_hden;
  logic [SNW-1:0]  c_snum;
  logic [DW-1:0]   c_sden;
  logic [TW-1:0]   c_tag;

  always_comb begin
    c_delta = s0_max - s0_min;
    c_num   = '0;
    case (s0_sec)
      SEC_R:   c_num = (s0_g >= s0_b) ? NUMW'(s0_g - s0_b)
                                      : NUMW'(6) * NUMW'(c_delta) - NUMW'(s0_b - s0_g);
      SEC_G:   c_num = NUMW'(2) * NUMW'(c_delta) + NUMW'(s0_b) - NUMW'(s0_r);
      SEC_B:   c_num = NUMW'(4) * NUMW'(c_delta) + NUMW'(s0_r) - NUMW'(s0_g);
      default: c_num = '0;
    endcase
    c_hnum = HNW'(120) * HNW'(c_num) + HNW'(c_delta);
    c_hden = (c_delta == '0) ? HDW'(1) : {c_delta, 1'b0};
    c_snum = {c_delta, {SF{1'b0}}};
    c_sden = (s0_max == '0) ? DW'(1) : s0_max;
    c_tag  = {s0_sec, s0_max, s0_user, (s0_max == '0)};
  end

  logic           s1_vld;
  logic [HNW-1:0] s1_hnum;
  logic [HDW-1:0] s1_hden;
  logic [SNW-1:0] s1_snum;
  logic [DW-1:0]  s1_sden;
  logic [TW-1:0]  s1_tag;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= s0_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_hnum <= c_hnum;
      s1_hden <= c_hden;
      s1_snum <= c_snum;
      s1_sden <= c_sden;
      s1_tag  <= c_tag;
    end
  end

  logic          hq_vld, sq_vld;
  logic [QW-1:0] hq, sq;
  logic [TW-1:0] hq_tag;
  logic          sat_tag_unused;

  hsv_div_pipe #(
    .NW   (HNW),
    .DENW (HDW),
    .QW   (QW),
    .TW   (TW)
  ) u_hue_div (
    .clk     (clk),
    .reset_b (reset_b),
    .en      (adv),
    .in_vld  (s1_vld),
    .in_num  (s1_hnum),
    .in_den  (s1_hden),
    .in_tag  (s1_tag),
    .out_vld (hq_vld),
    .out_quo (hq),
    .out_tag (hq_tag)
  );

  hsv_div_pipe #(
    .NW   (SNW),
    .DENW (DW),
    .QW   (QW),
    .TW   (1)
  ) u_sat_div (
    .clk     (clk),
    .reset_b (reset_b),
    .en      (adv),
    .in_vld  (s1_vld),
    .in_num  (s1_snum),
    .in_den  (s1_sden),
    .in_tag  (1'b0),
    .out_vld (sq_vld),
    .out_quo (sq),
    .out_tag (sat_tag_unused)
  );

  // Final stage: hue wrap, gray override, saturation clamp
  logic [1:0]       f_sec;
  logic [DW-1:0]    f_v;
  logic [UW-1:0]    f_user;
  logic             f_zmax;
  logic [HUE_W-1:0] f_h;
  logic [SF-1:0]    f_s;

  assign {f_sec, f_v, f_user, f_zmax} = hq_tag;

  always_comb begin
    f_h = hq[HUE_W-1:0];
    if (f_sec == SEC_GRAY || hq == QW'(HUE_FULL)) f_h = '0;
    f_s = sq[SF-1:0];
    if (f_zmax)           f_s = '0;
    else if (sq >= S_ONE) f_s = '1;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      out_valid <= 1'b0;
      out_h     <= '0;
      out_s     <= '0;
      out_v     <= '0;
      out_user  <= '0;
    end else if (adv) begin
      out_valid <= hq_vld && sq_vld;
      out_h     <= f_h;
      out_s     <= f_s;
      out_v     <= f_v;
      out_user  <= f_user;
    end
  end

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Scoreboard bench for rgb2hsv_stream: directed vectors, random stream with
// backpressure, mid-stream reset, and a wide-parameter instance.
module tb_rgb2hsv_stream;
  import rgb2hsv_pkg::*;

  localparam int DW   = 8;
  localparam int SF   = 11;
  localparam int UW   = 2;
  localparam int LAT  = qw(SF) + 3;
  localparam int WDW  = 10;
  localparam int WSF  = 14;
  localparam int WLAT = qw(WSF) + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_b;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_r, in_g, in_b, out_v;
  logic [UW-1:0] in_user, out_user;
  logic [8:0]    out_h;
  logic [SF-1:0] out_s;

  logic           w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [WDW-1:0] w_in_r, w_in_g, w_in_b, w_out_v;
  logic [UW-1:0]  w_in_user, w_out_user;
  logic [8:0]     w_out_h;
  logic [WSF-1:0] w_out_s;

  rgb2hsv_stream #(.DW(DW), .SF(SF), .UW(UW)) u_dut (
    .clk(clk), .reset_b(reset_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_user(out_user)
  );

  rgb2hsv_stream #(.DW(WDW), .SF(WSF), .UW(UW)) u_dut_w (
    .clk(clk), .reset_b(reset_b),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_r(w_in_r), .in_g(w_in_g), .in_b(w_in_b), .in_user(w_in_user),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_h(w_out_h), .out_s(w_out_s), .out_v(w_out_v), .out_user(w_out_user)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { int h; int s; int v; int u; } exp_t;
  typedef struct { int r; int g; int b; int h; int s; int v; } dvec_t;
  exp_t  sb[$];
  dvec_t dv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Hue = 60 deg * offset/delta with sector offsets 0/2/4, rounded half-up,
  // taken modulo 360; saturation = floor(delta/max) in 2^sf units, clamped.
  function automatic exp_t model(input int sf, input int r, input int g, input int b, input int u);
    exp_t e;
    int mx, mn, d, off, num, q;
    longint sq, one;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    e.v = mx;
    e.u = u;
    e.h = 0;
    if (d != 0) begin
      if (r == mx)      off = g - b;
      else if (g == mx) off = 2 * d + b - r;
      else              off = 4 * d + r - g;
      num = 120 * off + d;
      q = (num >= 0) ? num / (2 * d) : -((-num + 2 * d - 1) / (2 * d));
      e.h = ((q % 360) + 360) % 360;
    end
    one = longint'(1) << sf;
    if (mx == 0) e.s = 0;
    else begin
      sq  = (longint'(d) << sf) / mx;
      e.s = (sq >= one) ? int'(one - 1) : int'(sq);
    end
    return e;
  endfunction

  // Monitor: push on accept, pop and compare on output transfer, check stalls.
  logic          stall_prev = 1'b0;
  logic [8:0]    ph;
  logic [SF-1:0] ps;
  logic [DW-1:0] pv;
  logic [UW-1:0] pu;
  int            pix_n = 0;

  always @(negedge clk) begin
    if (!reset_b) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_h, out_s, out_v, out_user}, {1'b1, ph, ps, pv, pu});
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got h=%0d s=%0d v=%0d with empty scoreboard", out_h, out_s, out_v);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_h !== 9'(e.h) || out_s !== SF'(e.s) || out_v !== DW'(e.v) || out_user !== UW'(e.u)) begin
            failures++;
            $display("FAIL pix%0d: got h=%0d s=%0d v=%0d u=%0d, expected h=%0d s=%0d v=%0d u=%0d",
                     pix_n, out_h, out_s, out_v, out_user, e.h, e.s, e.v, e.u);
          end
          pix_n++;
        end
      end
      stall_prev = out_valid && !out_ready;
      ph = out_h; ps = out_s; pv = out_v; pu = out_user;
      if (in_valid && in_ready)
        sb.push_back(model(SF, int'(in_r), int'(in_g), int'(in_b), int'(in_user)));
    end
  end

  // Drive cnt vectors back-to-back into an idle pipe and check the outputs
  // arrive LAT cycles after the first accept, on consecutive cycles.
  task automatic run_burst(input int first, input int cnt);
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_r     = DW'(dv[first+i].r);
      in_g     = DW'(dv[first+i].g);
      in_b     = DW'(dv[first+i].b);
      in_user  = UW'(first + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = cnt;
    @(negedge clk);
    while (!out_valid && n < 4 * LAT) begin
      n++;
      @(negedge clk);
    end
    check("latency", n, LAT);
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) @(negedge clk);
      check("burst_valid", out_valid, 1);
      check("burst_h", out_h, dv[first+i].h);
      check("burst_s", out_s, dv[first+i].s);
      check("burst_v", out_v, dv[first+i].v);
    end
    @(posedge clk); #1;
  endtask

  task automatic rnd_pixel();
    int r, g, b;
    r = $urandom_range(0, 255);
    g = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    case ($urandom_range(0, 7))
      0: g = r;
      1: b = g;
      2: begin g = r; b = r; end
      3: b = r;
      default: ;
    endcase
    in_r = DW'(r); in_g = DW'(g); in_b = DW'(b);
    in_user = UW'($urandom_range(0, 3));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, sent, guard, stale;
    logic fire;
    dv.push_back('{255,   0,   0,   0, 2047, 255});
    dv.push_back('{  0, 255,   0, 120, 2047, 255});
    dv.push_back('{  0,   0, 255, 240, 2047, 255});
    dv.push_back('{255,   0,   1,   0, 2047, 255});
    dv.push_back('{200, 100, 150, 330, 1024, 200});
    dv.push_back('{  0,   0,   0,   0,    0,   0});
    dv.push_back('{128, 128, 128,   0,    0, 128});

    reset_b = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0; in_user = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_r = '0; w_in_g = '0; w_in_b = '0; w_in_user = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_h", out_h, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_v", out_v, 0);
    check("rst_out_user", out_user, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_out_valid", w_out_valid, 0);
    @(posedge clk); #1;
    reset_b = 1'b1;

    run_burst(0, 1);
    run_burst(1, 2);
    run_burst(3, 1);
    run_burst(4, 1);
    run_burst(5, 2);

    // Wide instance: full-scale red saturates to 2^14-1
    w_in_valid = 1'b1; w_in_r = 10'd1023; w_in_g = '0; w_in_b = '0; w_in_user = 2'd3;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!w_out_valid && n < 4 * WLAT) begin
      n++;
      @(negedge clk);
    end
    check("w_latency", n, WLAT);
    check("w_s", w_out_s, 16383);
    check("w_h", w_out_h, 0);
    check("w_v", w_out_v, 1023);
    check("w_user", w_out_user, 3);
    @(posedge clk); #1;

    // Random stream with bubbles and backpressure
    sent = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (fire) sent++;
      if (fire || !in_valid) begin
        in_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
        rnd_pixel();
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("random_sent", sent, 1000);
    n = 0;
    while (sb.size() != 0 && n < 10 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check("random_drain", sb.size(), 0);

    // Mid-stream reset with 10 pixels in flight
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rnd_pixel();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    stale = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    @(posedge clk); #1;
    run_burst(4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
